ins_decode_stage: RTL

INS_DECODE_STAGE -- requirements
Module: ins_decode_stage

---
 rtl/ins_pkg.sv | 51 +++++
 rtl/ins_imm_gen.sv | 72 +++++++
 rtl/ins_decode_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ins_pkg.sv
//------------------------------------------------------------------------------
// Module  : ins_pkg
// Brief   : Shared opcode constants, format encoding and decoded-field record
//           for the instruction decode stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ins_pkg;

    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_imm_32 = 7'b0011011;
    localparam logic [6:0] c_op_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ins_imm_gen.sv
//------------------------------------------------------------------------------
// Module  : ins_imm_gen
// Brief   : Pure combinational field split, format classification and
//           sign-extended immediate generation for one 32-bit instruction.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ins_imm_gen
    import ins_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output dec_fields_t     o_fields,
    output logic [XLEN-1:0] o_imm
);

    localparam bit c_rv64 = (XLEN == 64);

    fmt_e        w_fmt;
    logic [31:0] w_imm32;

    always_comb begin
        w_fmt = FMT_ILL;
        if (i_instr[1:0] == 2'b11) begin
            case (i_instr[6:0])
                c_op_op:                                        w_fmt = FMT_R;
                c_op_imm, c_op_load, c_op_jalr, c_op_system:    w_fmt = FMT_I;
                c_op_store:                                     w_fmt = FMT_S;
                c_op_branch:                                    w_fmt = FMT_B;
                c_op_lui, c_op_auipc:                           w_fmt = FMT_U;
                c_op_jal:                                       w_fmt = FMT_J;
                c_op_imm_32:    w_fmt = c_rv64 ? FMT_I : FMT_ILL;
                c_op_32:        w_fmt = c_rv64 ? FMT_R : FMT_ILL;
                default:        w_fmt = FMT_ILL;
            endcase
        end
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'h000};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Every format's 32-bit image already carries bit 31 as its sign.
    assign o_imm = XLEN'($signed(w_imm32));

    always_comb begin
        o_fields         = '0;
        o_fields.funct7  = i_instr[31:25];
        o_fields.rs2     = i_instr[24:20];
        o_fields.rs1     = i_instr[19:15];
        o_fields.funct3  = i_instr[14:12];
        o_fields.rd      = i_instr[11:7];
        o_fields.opcode  = i_instr[6:0];
        o_fields.fmt     = w_fmt;
        o_fields.illegal = (w_fmt == FMT_ILL);
    end

endmodule

`default_nettype wire

// File: rtl/ins_decode_stage.sv
//------------------------------------------------------------------------------
// Module  : ins_decode_stage
// Brief   : Instruction decode pipeline stage with a two-entry (main + skid)
//           buffer; in_ready is purely registered.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ins_decode_stage
    import ins_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("ins_decode_stage: XLEN must be 32 or 64");
    end

    dec_fields_t     w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    logic            w_deliver;

    logic            main_valid_q, main_valid_d;
    dec_fields_t     main_dec_q,   main_dec_d;
    logic [PC_W-1:0] main_pc_q,    main_pc_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic            skid_valid_q, skid_valid_d;
    dec_fields_t     skid_dec_q,   skid_dec_d;
    logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;

    ins_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr  (in_instr),
        .o_fields (w_dec),
        .o_imm    (w_imm)
    );

    assign in_ready  = !skid_valid_q;
    assign w_accept  = in_valid && !skid_valid_q;
    assign w_deliver = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_dec_d   = main_dec_q;
        main_pc_d    = main_pc_q;
        main_imm_d   = main_imm_q;
        skid_valid_d = skid_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Full: input is stalled, skid refills main once main drains.
            if (w_deliver) begin
                main_dec_d   = skid_dec_q;
                main_pc_d    = skid_pc_q;
                main_imm_d   = skid_imm_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || w_deliver) begin
            main_valid_d = w_accept;
            if (w_accept) begin
                main_dec_d = w_dec;
                main_pc_d  = in_pc;
                main_imm_d = w_imm;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_dec_d   = w_dec;
            skid_pc_d    = in_pc;
            skid_imm_d   = w_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_dec_q   <= '0;
            main_pc_q    <= '0;
            main_imm_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_dec_q   <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_dec_q   <= main_dec_d;
            main_pc_q    <= main_pc_d;
            main_imm_q   <= main_imm_d;
            skid_valid_q <= skid_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_pc_q;
    assign out_opcode  = main_dec_q.opcode;
    assign out_rd      = main_dec_q.rd;
    assign out_funct3  = main_dec_q.funct3;
    assign out_rs1     = main_dec_q.rs1;
    assign out_rs2     = main_dec_q.rs2;
    assign out_funct7  = main_dec_q.funct7;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_dec_q.fmt;
    assign out_illegal = main_dec_q.illegal;

endmodule

`default_nettype wire
